// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 UART receiver with mid-bit sampling, valid/ready output,
// framing-error and overrun pulses.
module uart_rx_deframer #(
  parameter int CLK_DIVIDER = 200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);
  localparam int CW = $clog2(CLK_DIVIDER);
  localparam logic [CW-1:0] L_HALF = CW'(CLK_DIVIDER / 2 - 1);
  localparam logic [CW-1:0] L_FULL = CW'(CLK_DIVIDER - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_done;
  logic          w_rx, w_tick, w_load_half, w_shift, w_done, w_ferr;

  assign w_rx   = r_sync[1];
  assign w_tick = (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;

  always_comb begin
    w_next      = r_state;
    w_load_half = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE:  if (!w_rx) begin
               w_next      = START;
               w_load_half = 1'b1;
             end
      START: if (w_tick) w_next = w_rx ? IDLE : DATA;
      DATA:  if (w_tick) begin
               w_shift = 1'b1;
               w_next  = (r_idx == 3'd7) ? STOP : DATA;
             end
      STOP:  if (w_tick) begin
               w_next = w_rx ? IDLE : BRK;
               w_done = w_rx;
               w_ferr = !w_rx;
             end
      BRK:   if (w_rx) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: synchroniser, bit timer, bit index and deserialiser.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_uart_rx};
      r_cnt   <= w_load_half ? L_HALF : w_tick ? L_FULL : r_cnt - CW'(1);
      r_idx   <= (r_state == START) ? 3'd0 : w_shift ? r_idx + 3'd1 : r_idx;
      r_shift <= w_shift ? {w_rx, r_shift[7:1]} : r_shift;
      r_done  <= w_done;
    end

  // Holding register: a delivery coinciding with acceptance refills without a gap.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= w_ferr;
      o_overrun   <= r_done && o_valid && !i_ready;
      if (r_done && (!o_valid || i_ready)) begin
        o_data  <= r_shift;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed frames into a DIV=200 receiver plus a 256-byte
// transmitter loopback into a DIV=16 receiver; scoreboard queues checked by monitors.
module tb_uart_rx_deframer;
  localparam int DIV  = 200;
  localparam int DIV2 = 16;

  logic       clk = 1'b0;
  logic       rst_n, rx, rx2, ready;
  logic [7:0] o_data, o_data2;
  logic       o_valid, o_valid2, o_ferr, o_ferr2, o_ovr, o_ovr2;

  int total = 0, bad = 0;
  int cyc = 0, t_edge = 0, first_valid_cyc = -1;
  int n_rx = 0, n_rx2 = 0, ferr_cnt = 0, ovr_cnt = 0;
  logic [7:0] exp_q[$], exp2_q[$];
  logic       pv, pr;
  logic [7:0] pd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx_deframer #(.CLK_DIVIDER(DIV)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx), .o_data(o_data), .o_valid(o_valid),
    .i_ready(ready), .o_frame_err(o_ferr), .o_overrun(o_ovr));

  uart_rx_deframer #(.CLK_DIVIDER(DIV2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx2), .o_data(o_data2), .o_valid(o_valid2),
    .i_ready(1'b1), .o_frame_err(o_ferr2), .o_overrun(o_ovr2));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      pr = 1'b0;
      pd = '0;
    end else begin
      if (o_valid && !pv && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pv && !pr && o_valid) chk("data_stable", {24'd0, o_data}, {24'd0, pd});
      if (o_valid && ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte got=%0h want=none", o_data);
        end else begin
          chk("rx_byte", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
          n_rx++;
        end
      end
      if (o_ferr) ferr_cnt++;
      if (o_ovr) ovr_cnt++;
      pv = o_valid;
      pr = ready;
      pd = o_data;
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (o_valid2) begin
      if (exp2_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL loop_unexpected got=%0h want=none", o_data2);
      end else begin
        chk("loop_byte", {24'd0, o_data2}, {24'd0, exp2_q.pop_front()});
        n_rx2++;
      end
    end
    if (o_ferr2 || o_ovr2) begin
      total++;
      bad++;
      $display("FAIL loop_flags got=%0b%0b want=00", o_ferr2, o_ovr2);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit l2, input logic v, input int n);
    if (l2) rx2 = v;
    else rx = v;
    wait_clk(n);
  endtask

  // low_tail > 0 replaces the stop bit with that many bit-times of low line.
  task automatic send(input bit l2, input logic [7:0] b, input int low_tail);
    int d;
    d = l2 ? DIV2 : DIV;
    if (!l2) begin
      t_edge = cyc;
      first_valid_cyc = -1;
    end
    drive(l2, 1'b0, d);
    for (int i = 0; i < 8; i++) drive(l2, b[i], d);
    if (low_tail > 0) drive(l2, 1'b0, low_tail * d);
    drive(l2, 1'b1, d);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0;
    rx    = 1'b1;
    rx2   = 1'b1;
    ready = 1'b0;
    wait_clk(5);
    chk("rst_data", {24'd0, o_data}, 0);
    chk("rst_valid", {31'd0, o_valid}, 0);
    chk("rst_ferr", {31'd0, o_ferr}, 0);
    chk("rst_ovr", {31'd0, o_ovr}, 0);
    rst_n = 1'b1;
    wait_clk(10);

    exp_q.push_back(8'h41);
    send(1'b0, 8'h41, 0);
    wait_clk(100);
    chk("hold_valid", {31'd0, o_valid}, 1);
    chk("hold_data", {24'd0, o_data}, 32'h41);
    total++;
    if (first_valid_cyc - t_edge < 1902 || first_valid_cyc - t_edge > 1904) begin
      bad++;
      $display("FAIL latency got=%0d want=1903+/-1", first_valid_cyc - t_edge);
    end
    ready = 1'b1;
    wait_clk(1);
    chk("drop_valid", {31'd0, o_valid}, 0);
    chk("n_rx_41", n_rx, 1);

    rx = 1'b0;
    wait_clk(50);
    rx = 1'b1;
    wait_clk(300);
    chk("glitch_valid", {31'd0, o_valid}, 0);
    chk("glitch_ferr", ferr_cnt, 0);
    exp_q.push_back(8'h5A);
    send(1'b0, 8'h5A, 0);
    wait_clk(50);
    chk("n_rx_5a", n_rx, 2);

    send(1'b0, 8'h55, 5);
    wait_clk(2 * DIV);
    chk("break_ferr", ferr_cnt, 1);
    chk("break_valid", {31'd0, o_valid}, 0);
    exp_q.push_back(8'hA5);
    send(1'b0, 8'hA5, 0);
    wait_clk(50);
    chk("n_rx_a5", n_rx, 3);
    chk("ferr_after_a5", ferr_cnt, 1);

    ready = 1'b0;
    exp_q.push_back(8'h12);
    send(1'b0, 8'h12, 0);
    send(1'b0, 8'h34, 0);
    wait_clk(100);
    chk("ovr_cnt", ovr_cnt, 1);
    chk("ovr_data", {24'd0, o_data}, 32'h12);
    chk("ovr_valid", {31'd0, o_valid}, 1);
    ready = 1'b1;
    wait_clk(1);
    chk("ovr_drop", {31'd0, o_valid}, 0);
    chk("n_rx_12", n_rx, 4);

    foreach (exp_q[i]) ;
    base = n_rx;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h01);
    send(1'b0, 8'h00, 0);
    send(1'b0, 8'hFF, 0);
    send(1'b0, 8'h80, 0);
    send(1'b0, 8'h01, 0);
    wait_clk(50);
    chk("stream_cnt", n_rx - base, 4);
    chk("stream_flags", ferr_cnt + ovr_cnt, 2);

    ready = 1'b0;
    exp_q.push_back(8'h99);
    send(1'b0, 8'h99, 0);
    wait_clk(20);
    chk("pre_rst_valid", {31'd0, o_valid}, 1);
    drive(1'b0, 1'b0, DIV);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'(8'hC3 >> i), DIV);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", {24'd0, o_data}, 0);
    chk("mid_rst_valid", {31'd0, o_valid}, 0);
    chk("mid_rst_ferr", {31'd0, o_ferr}, 0);
    chk("mid_rst_ovr", {31'd0, o_ovr}, 0);
    exp_q.delete();
    rx = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(10);
    ready = 1'b1;
    base = n_rx;
    exp_q.push_back(8'hC3);
    send(1'b0, 8'hC3, 0);
    wait_clk(50);
    chk("n_rx_c3", n_rx - base, 1);

    for (int b = 0; b < 256; b++) exp2_q.push_back(8'(b));
    for (int b = 0; b < 256; b++) send(1'b1, 8'(b), 0);
    wait_clk(50);
    chk("loop_cnt", n_rx2, 256);
    chk("loop_left", exp2_q.size(), 0);
    chk("main_left", exp_q.size(), 0);
    chk("main_ferr_total", ferr_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
